// File: rtl/edge_event_arbiter.sv
// Multi-channel edge/pulse event collector. Each line has its own detector: off, rising,
// falling, or one-cycle pulse (010). Detected events are held as pending and delivered
// one at a time on a valid/ready port, with round-robin arbitration between channels.
// Latency: an edge sampled at posedge k sets pending at k. The event is presented
// (ev_valid) at k+1 when the slot is free. With ev_ready held high, events go out at
// one per cycle.
// Backpressure: while ev_valid & ~ev_ready, ev_valid and ev_id hold and no grant occurs.
// Each channel queues at most one further event. A later event on that channel is
// dropped and sets its sticky overflow bit.
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   a[N]           input lines (already synchronised to clk)
//   mode[2N]       per-channel mode, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 pulse
//   ev_valid/ev_ready/ev_id   event output port
//   overflow[N]    sticky per-channel drop flag
//   clr_ovf        clears overflow (a simultaneous new drop wins)
// Parameters: N channels (2..16), ID_W event-id width (2**ID_W >= N).
module edge_event_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      a,
   input  logic [2*N-1:0]    mode,
   output logic              ev_valid,
   input  logic              ev_ready,
   output logic [ID_W-1:0]   ev_id,
   output logic [N-1:0]      overflow,
   input  logic              clr_ovf
);

   logic [N-1:0]    a1_r;
   logic [N-1:0]    a2_r;
   logic [N-1:0]    pending;
   logic [N-1:0]    det;
   logic [N-1:0]    gnt_oh;
   logic [N-1:0]    ovf_set;
   logic [N-1:0]    pending_nxt;
   logic [ID_W-1:0] last;
   logic [ID_W-1:0] gnt_idx;
   logic            gnt_vld;
   logic            slot_load;

   // Per-channel edge detect from the current input and two cycles of history.
   always_comb begin
      det = '0;
      for (int c = 0; c < N; c++) begin
         case (mode[2*c +: 2])
            2'b01:   det[c] = a[c] & ~a1_r[c];
            2'b10:   det[c] = ~a[c] & a1_r[c];
            // Only a high phase of exactly one cycle (0,1,0) is reported.
            2'b11:   det[c] = ~a[c] & a1_r[c] & ~a2_r[c];
            default: det[c] = 1'b0;
         endcase
      end
   end

   // The slot takes a new event when it is empty or its event is being accepted.
   assign slot_load = ~ev_valid | ev_ready;

   // Round-robin scan of the registered pending bits, starting at last+1.
   // The doubled vector is shifted so that bit j of rot is channel (last+1+j) mod N.
   always_comb begin : grant_scan
      logic [2*N-1:0] dbl;
      logic [N-1:0]   rot;
      int             pos;
      dbl     = {pending, pending};
      rot     = N'(dbl >> (int'(last) + 1));
      pos     = 0;
      gnt_vld = 1'b0;
      gnt_idx = last;
      for (int j = 0; j < N; j++) begin
         if (!gnt_vld && rot[j]) begin
            gnt_vld = 1'b1;
            pos     = int'(last) + 1 + j;
            if (pos >= N) begin
               pos = pos - N;
            end
            gnt_idx = ID_W'(pos);
         end
      end
   end

   always_comb begin
      gnt_oh = '0;
      for (int c = 0; c < N; c++) begin
         gnt_oh[c] = slot_load & gnt_vld & (int'(gnt_idx) == c);
      end
   end

   // A channel granted in the same cycle as a new detect stays pending for the new
   // event. An ungranted channel that is already pending drops the event.
   assign pending_nxt = det | (pending & ~gnt_oh);
   assign ovf_set     = det & pending & ~gnt_oh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a1_r     <= '0;
         a2_r     <= '0;
         pending  <= '0;
         overflow <= '0;
         ev_valid <= 1'b0;
         ev_id    <= '0;
         last     <= ID_W'(N - 1);
      end else begin
         a1_r     <= a;
         a2_r     <= a1_r;
         pending  <= pending_nxt;
         overflow <= ovf_set | (overflow & {N{~clr_ovf}});
         if (slot_load) begin
            if (gnt_vld) begin
               ev_valid <= 1'b1;
               ev_id    <= gnt_idx;
               last     <= gnt_idx;
            end else begin
               ev_valid <= 1'b0;
            end
         end
      end
   end

endmodule
